// File: rtl/mem_responder.sv
// Word-array memory responder for the CPU bus: accepts READ/WRITE commands,
// answers writes and errors in one cycle and reads after READ_LATENCY cycles.
module mem_responder #(
    parameter int ADDR_W       = 9,
    parameter int DATA_W       = 16,
    parameter int DEPTH        = 512,
    parameter int READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        mem_cmd,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              mem_ready,
    output logic              mem_err,
    output logic              busy
);

    localparam int         IDX_W  = $clog2(DEPTH);
    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [2:0] LAT_M1 = 3'(READ_LATENCY - 1);

    typedef enum logic {
        IDLE,
        RD_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic                mem_we;
    logic                cmd_bad;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    assign cmd_bad = (mem_cmd == 2'b11) || (32'(mem_addr) >= DEPTH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // Array contents are deliberately left unreset; a write commits at its own acceptance edge.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_addr[IDX_W-1:0]] <= write_data;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (reset_n && mem_cmd != CMD_NONE) begin
                    addr_d = mem_addr;
                    if (cmd_bad) begin
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                    end else if (mem_cmd == CMD_WRITE) begin
                        mem_we  = 1'b1;
                        ready_d = 1'b1;
                    end else if (mem_cmd == CMD_READ && READ_LATENCY == 1) begin
                        rdata_d = mem_q[mem_addr[IDX_W-1:0]];
                        ready_d = 1'b1;
                    end else begin
                        state_d = RD_WAIT;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            RD_WAIT: begin
                // The read completes on the edge where the counter has reached one.
                if (cnt_q == 3'd1) begin
                    rdata_d = mem_q[addr_q[IDX_W-1:0]];
                    ready_d = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        read_data = rdata_q;
        mem_ready = ready_q;
        mem_err   = err_q;
        busy      = (state_q == RD_WAIT);
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (full depth / latency 2, and half depth /
// latency 1) driven by directed and random commands against a transaction-level model.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  cmdS   [2];
    logic [8:0]  addrS  [2];
    logic [15:0] wdS    [2];
    logic [15:0] rdataS [2];
    logic        readyS [2];
    logic        errS   [2];
    logic        busyS  [2];

    int depthS [2] = '{512, 256};
    int latS   [2] = '{2, 1};
    logic [15:0] modelMem [2][512];
    bit          written  [2][512];
    logic [15:0] modelRd  [2];

    int passCount = 0;
    int totalCount = 0;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(9), .DATA_W(16), .DEPTH(512), .READ_LATENCY(2)) dut (
        .clk(clk), .reset_n(reset_n), .mem_cmd(cmdS[0]), .mem_addr(addrS[0]),
        .write_data(wdS[0]), .read_data(rdataS[0]), .mem_ready(readyS[0]),
        .mem_err(errS[0]), .busy(busyS[0])
    );

    mem_responder #(.ADDR_W(9), .DATA_W(16), .DEPTH(256), .READ_LATENCY(1)) dutSmall (
        .clk(clk), .reset_n(reset_n), .mem_cmd(cmdS[1]), .mem_addr(addrS[1]),
        .write_data(wdS[1]), .read_data(rdataS[1]), .mem_ready(readyS[1]),
        .mem_err(errS[1]), .busy(busyS[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCount++;
        assert (obs === exp) passCount++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Issue one command on instance s and check latency, error flag, busy and read data.
    task automatic runCmd(input int s, input logic [1:0] cmd, input logic [8:0] addr,
                          input logic [15:0] data);
        bit expErr;
        int expLat;
        int lat;
        int busyBad;
        expErr = (cmd == 2'b11) || (int'(addr) >= depthS[s]);
        expLat = (!expErr && cmd == 2'b01) ? latS[s] : 1;
        @(negedge clk);
        cmdS[s] = cmd; addrS[s] = addr; wdS[s] = data;
        @(posedge clk);
        #1;
        cmdS[s] = 2'b00; addrS[s] = 9'($urandom); wdS[s] = 16'($urandom);
        if (!expErr && cmd == 2'b10) begin
            modelMem[s][addr] = data;
            written[s][addr] = 1'b1;
        end else if (!expErr && cmd == 2'b01) begin
            modelRd[s] = modelMem[s][addr];
        end
        lat = 0;
        busyBad = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (busyS[s] !== (lat < expLat)) busyBad++;
            if (readyS[s] === 1'b1) break;
        end
        check($sformatf("lat[%0d] cmd%0d a%0h", s, cmd, addr), lat, expLat);
        check($sformatf("err[%0d] cmd%0d a%0h", s, cmd, addr), errS[s], expErr);
        check($sformatf("busy[%0d] cmd%0d a%0h", s, cmd, addr), busyBad, 0);
        check($sformatf("rdata[%0d] cmd%0d a%0h", s, cmd, addr), rdataS[s], modelRd[s]);
        @(negedge clk);
        check($sformatf("single pulse[%0d]", s), {readyS[s], errS[s]}, 2'b00);
    endtask

    initial begin
        int lat;
        int readyCount;
        logic [1:0] rc;
        logic [8:0] ra;
        for (int s = 0; s < 2; s++) begin
            cmdS[s] = 2'b00; addrS[s] = '0; wdS[s] = '0; modelRd[s] = '0;
        end

        // Power-on reset values
        #3;
        for (int s = 0; s < 2; s++) begin
            check($sformatf("reset state[%0d]", s),
                  {rdataS[s], readyS[s], errS[s], busyS[s]}, 19'h0);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Write then read with latency 2
        runCmd(0, 2'b10, 9'h005, 16'hBEEF);
        runCmd(0, 2'b01, 9'h005, 16'h0000);
        repeat (3) @(negedge clk);
        check("rdata hold", rdataS[0], 16'hBEEF);

        // Busy hold-off: a WRITE presented during the read waits for the ready cycle
        @(negedge clk);
        cmdS[0] = 2'b01; addrS[0] = 9'h005;
        @(posedge clk);
        #1;
        cmdS[0] = 2'b10; addrS[0] = 9'h006; wdS[0] = 16'h1234;
        @(negedge clk);
        check("holdoff busy", {busyS[0], readyS[0]}, 2'b10);
        @(negedge clk);
        check("holdoff read ready", {busyS[0], readyS[0], errS[0]}, 3'b010);
        check("holdoff read data", rdataS[0], 16'hBEEF);
        @(negedge clk);
        check("holdoff write ready", {busyS[0], readyS[0], errS[0]}, 3'b010);
        cmdS[0] = 2'b00;
        modelMem[0][9'h006] = 16'h1234;
        written[0][9'h006] = 1'b1;
        @(negedge clk);
        check("holdoff no extra", readyS[0], 1'b0);
        runCmd(0, 2'b01, 9'h006, 16'h0000);
        runCmd(0, 2'b01, 9'h005, 16'h0000);

        // Sequential fill, one write per cycle
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i > 0) check($sformatf("b2b write ready %0d", i - 1), {readyS[0], errS[0]}, 2'b10);
            cmdS[0] = 2'b10; addrS[0] = 9'(i); wdS[0] = 16'(i) + 16'h0100;
            modelMem[0][i] = 16'(i) + 16'h0100;
            written[0][i] = 1'b1;
        end
        @(negedge clk);
        check("b2b write ready 15", {readyS[0], errS[0]}, 2'b10);

        // Back-to-back reads: each next READ is presented during the ready cycle
        cmdS[0] = 2'b01;
        for (int i = 0; i < 16; i++) begin
            addrS[0] = 9'(i);
            lat = 0;
            while (lat < 20) begin
                @(negedge clk);
                lat++;
                if (readyS[0] === 1'b1) break;
            end
            check($sformatf("fetch spacing %0d", i), lat, latS[0]);
            check($sformatf("fetch data %0d", i), rdataS[0], 16'(i) + 16'h0100);
        end
        cmdS[0] = 2'b00;
        modelRd[0] = 16'h010F;
        @(negedge clk);

        // Top word and reserved command
        runCmd(0, 2'b10, 9'h1FF, 16'hC0DE);
        runCmd(0, 2'b01, 9'h1FF, 16'h0000);
        runCmd(0, 2'b11, 9'h007, 16'hFFFF);

        // Out-of-range addresses on the half-depth instance
        runCmd(1, 2'b10, 9'h000, 16'hAAAA);
        runCmd(1, 2'b01, 9'h000, 16'h0000);
        runCmd(1, 2'b01, 9'h100, 16'h0000);
        runCmd(1, 2'b10, 9'h100, 16'h5555);
        runCmd(1, 2'b01, 9'h000, 16'h0000);
        runCmd(1, 2'b11, 9'h010, 16'h0000);

        // Randomized mix on both instances
        for (int n = 0; n < 30; n++) begin
            for (int s = 0; s < 2; s++) begin
                rc = 2'($urandom_range(1, 3));
                ra = 9'($urandom);
                if (rc == 2'b01 && !written[s][ra] && int'(ra) < depthS[s]) rc = 2'b10;
                runCmd(s, rc, ra, 16'($urandom));
            end
        end

        // Reset in the middle of a read
        @(negedge clk);
        cmdS[0] = 2'b01; addrS[0] = 9'h005;
        @(posedge clk);
        #1;
        cmdS[0] = 2'b00;
        #1;
        check("midread busy", busyS[0], 1'b1);
        #1;
        reset_n = 1'b0;
        #1;
        check("async reset", {rdataS[0], readyS[0], errS[0], busyS[0]}, 19'h0);
        modelRd[0] = '0;
        modelRd[1] = '0;
        @(negedge clk);
        reset_n = 1'b1;
        readyCount = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (readyS[0] !== 1'b0) readyCount++;
        end
        check("no ready after abort", readyCount, 0);
        check("rdata after abort", rdataS[0], 16'h0000);
        runCmd(0, 2'b01, 9'h005, 16'h0000);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
